mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32 pipeline, directly downstream of the EX/MEM register.
- Consumes memread/memwrite/regwrite/rd/ALU result plus store data and funct3.
- Runs a req/ack data-memory bus transaction with lane alignment and sign extension.
- Stalls the pipeline while the memory is busy and registers results into the MEM/WB boundary.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- ADDR_W, 32, byte-address width driven on the bus.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- memread_MEM  in  1  load in MEM
- memwrite_MEM  in  1  store in MEM
- regwrite_MEM  in  1  instruction writes rd
- rd_MEM  in  5  destination register
- ALU_data_MEM  in  32  ALU result / effective byte address
- store_data_MEM  in  32  rs2 value for stores
- funct3_MEM  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  one-cycle completion
- stall_MEM  out  1  freeze IF..EX/MEM
- regwrite_WB  out  1  registered write enable
- rd_WB  out  5  registered rd
- wb_data_WB  out  32  registered writeback data
- misalign_WB  out  1  registered misaligned-access flag
- misalign_addr_WB  out  32  faulting address

Behaviour:
- Reset: state IDLE; regwrite_WB=0, rd_WB=0, wb_data_WB=0, misalign_WB=0, misalign_addr_WB=0; mem_req=0 and stall_MEM=0 immediately (async).
- access = memread_MEM | memwrite_MEM. If both are set, the access is treated as a store.
- FSM states: IDLE, WAIT.
  - mem_req = (IDLE & access & ~misaligned) | WAIT. Driven combinationally.
  - IDLE->WAIT when mem_req & ~mem_ack. WAIT->IDLE when mem_ack. All other cases hold state.
- stall_MEM = mem_req & ~mem_ack.
  - A zero-wait ack (same cycle as req) completes with no stall.
  - Upstream holds all *_MEM inputs stable while stall_MEM=1; the bus relies on this for address/data stability.
- Bus rules:
  - mem_req stays high until ack.
  - mem_ack is honoured only while mem_req=1; a stray ack in IDLE with no access is ignored.
- Store lanes:
  - SB: wdata = {4{b}}, wstrb = 0001<<addr[1:0].
  - SH: wdata = {2{h}}, wstrb = 0011<<addr[1:0].
  - SW: wstrb = 1111.
- Load extraction: select the byte/half from mem_rdata by addr[1:0]; sign-extend for B/H, zero-extend for BU/HU.
- WB register update each cycle:
  - stall_MEM=1: regwrite_WB<=0 (bubble); rd_WB and wb_data_WB hold.
  - Completed load: wb_data_WB<=extracted data, regwrite_WB<=regwrite_MEM.
  - Store: regwrite_WB<=0.
  - Non-memory op: wb_data_WB<=ALU_data_MEM, regwrite_WB<=regwrite_MEM.
  - rd_MEM==0 passes through unchanged; the regfile ignores x0.
- Reset mid-transaction: FSM returns to IDLE and mem_req drops asynchronously. The memory must tolerate an abandoned request; any late ack is ignored.
- Latency: one cycle from ack (or from a non-memory op) to WB outputs.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - Misaligned = (H/HU/SH & addr[0]) | (W/SW & addr[1:0]!=0).
  - A misaligned access issues no mem_req and causes no stall.
  - Next cycle: misalign_WB=1 for one cycle, misalign_addr_WB=ALU_data_MEM, regwrite_WB=0.
- Undefined:
  - misaligned is tied 0; misalign_WB and misalign_addr_WB are tied 0.
  - H accesses use addr[1] only; W accesses ignore addr[1:0].

Decomposition:
- Package riscv_mem_pkg:
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - FSM state enum {IDLE, WAIT}.
  - XLEN constant.
- Sub-module load_store_align: combinational wstrb/wdata generation, load extraction/extension and misalign detect. The FSM and WB register stay in mem_stage.

Test Plan:
- Non-memory op: ALU_data=0x0000_1234, rd=5, regwrite=1 -> next cycle regwrite_WB=1, rd_WB=5, wb_data_WB=0x1234; mem_req never high.
- LB with addr=0x103, 3-cycle ack delay, mem_rdata=0x80FF_0000 -> mem_addr=0x100; stall_MEM high for 3 cycles; regwrite_WB=0 during stall; then wb_data_WB=0xFFFF_FF80.
- LHU with addr=0x202, zero-wait ack, rdata=0xBEEF_1234 -> no stall; wb_data_WB=0x0000_BEEF.
- SB with addr=0x301, data=0x0000_00AB -> mem_we=1, wstrb=0010, wdata=0xABAB_ABAB; regwrite_WB=0.
- Reset asserted in WAIT -> mem_req and stall_MEM drop immediately; all WB outputs 0; a following ack is ignored.
- With MISALIGN_CHECK_EN, LW at addr=0x402 -> no mem_req; misalign_WB=1 for one cycle; misalign_addr_WB=0x402; regwrite_WB=0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32 MEM stage: funct3 access codes,
// bus FSM states and datapath width.
package riscv_mem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Store lane steering, load extraction/extension and misalign detect.
// MISALIGN_CHECK_EN enables the misaligned-access flag.
module load_store_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            misaligned_o
);

  logic        is_h;
  logic        is_w;
  logic        uns;
  logic [1:0]  h_off;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign is_h = (funct3_i == F3_LH) | (funct3_i == F3_LHU)
              | (funct3_i == F3_SH);
  assign is_w = (funct3_i == F3_LW) | (funct3_i == F3_SW);
  assign uns  = (funct3_i == F3_LBU) | (funct3_i == F3_LHU);

  // Halfwords only ever look at addr[1]; addr[0] is the misalign bit.
  assign h_off  = {addr_i[1], 1'b0};
  assign byte_v = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    wdata_o     = store_data_i;
    wstrb_o     = 4'b1111;
    load_data_o = rdata_i;
    unique case (1'b1)
      is_w: begin
        wdata_o     = store_data_i;
        wstrb_o     = 4'b1111;
        load_data_o = rdata_i;
      end
      is_h: begin
        wdata_o     = {2{store_data_i[15:0]}};
        wstrb_o     = 4'b0011 << h_off;
        load_data_o = uns ? {16'b0, half_v}
                          : {{16{half_v[15]}}, half_v};
      end
      default: begin
        wdata_o     = {4{store_data_i[7:0]}};
        wstrb_o     = 4'b0001 << addr_i;
        load_data_o = uns ? {24'b0, byte_v}
                          : {{24{byte_v[7]}}, byte_v};
      end
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  assign misaligned_o = (is_h & addr_i[0])
                      | (is_w & (addr_i != 2'b00));
`else
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM stage: req/ack data bus FSM, stall and MEM/WB register.
// MISALIGN_CHECK_EN enables misaligned-access trapping to WB.
module mem_stage
  import riscv_mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread_MEM,
  input  logic              memwrite_MEM,
  input  logic              regwrite_MEM,
  input  logic [4:0]        rd_MEM,
  input  logic [XLEN-1:0]   ALU_data_MEM,
  input  logic [XLEN-1:0]   store_data_MEM,
  input  logic [2:0]        funct3_MEM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              stall_MEM,
  output logic              regwrite_WB,
  output logic [4:0]        rd_WB,
  output logic [XLEN-1:0]   wb_data_WB,
  output logic              misalign_WB,
  output logic [XLEN-1:0]   misalign_addr_WB
);

  mem_state_e      state_q;
  logic            access;
  logic            mis_raw;
  logic            misaligned;
  logic [XLEN-1:0] load_data;
  logic            regwrite_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] wb_data_q;

  load_store_align u_align (
    .addr_i       (ALU_data_MEM[1:0]),
    .funct3_i     (funct3_MEM),
    .store_data_i (store_data_MEM),
    .rdata_i      (mem_rdata),
    .wdata_o      (mem_wdata),
    .wstrb_o      (mem_wstrb),
    .load_data_o  (load_data),
    .misaligned_o (mis_raw)
  );

  assign access     = memread_MEM | memwrite_MEM;
  assign misaligned = access & mis_raw;

  // Gated by reset so the request drops even if upstream still asserts access.
  assign mem_req = ~reset
                 & (((state_q == IDLE) & access & ~misaligned)
                 |  (state_q == WAIT));
  assign mem_we    = mem_req & memwrite_MEM;
  assign mem_addr  = {ALU_data_MEM[ADDR_W-1:2], 2'b00};
  assign stall_MEM = mem_req & ~mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (mem_req & ~mem_ack) state_q <= WAIT;
        WAIT: if (mem_ack) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      wb_data_q  <= '0;
    end else if (stall_MEM) begin
      regwrite_q <= 1'b0;
    end else begin
      rd_q <= rd_MEM;
      if (misaligned || memwrite_MEM) begin
        regwrite_q <= 1'b0;
      end else if (memread_MEM) begin
        wb_data_q  <= load_data;
        regwrite_q <= regwrite_MEM;
      end else begin
        wb_data_q  <= ALU_data_MEM;
        regwrite_q <= regwrite_MEM;
      end
    end
  end

  assign regwrite_WB = regwrite_q;
  assign rd_WB       = rd_q;
  assign wb_data_WB  = wb_data_q;

`ifdef MISALIGN_CHECK_EN
  logic            mis_q;
  logic [XLEN-1:0] mis_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      mis_q <= misaligned & ~stall_MEM;
      if (misaligned) mis_addr_q <= ALU_data_MEM;
    end
  end

  assign misalign_WB      = mis_q;
  assign misalign_addr_WB = mis_addr_q;
`else
  assign misalign_WB      = 1'b0;
  assign misalign_addr_WB = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: bus handshake, lanes, extension,
// stall bubbles, reset abort and (MISALIGN_CHECK_EN) misalign trap.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread_MEM, memwrite_MEM, regwrite_MEM;
  logic [4:0]  rd_MEM;
  logic [31:0] ALU_data_MEM, store_data_MEM;
  logic [2:0]  funct3_MEM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_MEM, regwrite_WB;
  logic [4:0]  rd_WB;
  logic [31:0] wb_data_WB;
  logic        misalign_WB;
  logic [31:0] misalign_addr_WB;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .memread_MEM      (memread_MEM),
    .memwrite_MEM     (memwrite_MEM),
    .regwrite_MEM     (regwrite_MEM),
    .rd_MEM           (rd_MEM),
    .ALU_data_MEM     (ALU_data_MEM),
    .store_data_MEM   (store_data_MEM),
    .funct3_MEM       (funct3_MEM),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack),
    .stall_MEM        (stall_MEM),
    .regwrite_WB      (regwrite_WB),
    .rd_WB            (rd_WB),
    .wb_data_WB       (wb_data_WB),
    .misalign_WB      (misalign_WB),
    .misalign_addr_WB (misalign_addr_WB)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    memread_MEM    = 1'b0;
    memwrite_MEM   = 1'b0;
    regwrite_MEM   = 1'b0;
    rd_MEM         = 5'd0;
    ALU_data_MEM   = 32'h0;
    store_data_MEM = 32'h0;
    funct3_MEM     = 3'b000;
    mem_rdata      = 32'h0;
    mem_ack        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic rd_en, input logic wr_en,
                    input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] sd, input logic [4:0] rd,
                    input logic ack, input logic [31:0] rdat);
    memread_MEM    = rd_en;
    memwrite_MEM   = wr_en;
    regwrite_MEM   = 1'b1;
    funct3_MEM     = f3;
    ALU_data_MEM   = a;
    store_data_MEM = sd;
    rd_MEM         = rd;
    mem_ack        = ack;
    mem_rdata      = rdat;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    memread_MEM = 1'b1;
    #2;
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_stall", 32'(stall_MEM), 32'h0);
    chk("rst_rw", 32'(regwrite_WB), 32'h0);
    chk("rst_rd", 32'(rd_WB), 32'h0);
    chk("rst_data", wb_data_WB, 32'h0);
    chk("rst_mis", 32'(misalign_WB), 32'h0);
    chk("rst_misaddr", misalign_addr_WB, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle_in();

    // Non-memory op
    @(negedge clk);
    regwrite_MEM = 1'b1;
    rd_MEM       = 5'd5;
    ALU_data_MEM = 32'h0000_1234;
    #1 chk("alu_req", 32'(mem_req), 32'h0);
    tick();
    chk("alu_rw", 32'(regwrite_WB), 32'h1);
    chk("alu_rd", 32'(rd_WB), 32'd5);
    chk("alu_data", wb_data_WB, 32'h0000_1234);

    // LB, three stall cycles before ack
    @(negedge clk);
    op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_req", 32'(mem_req), 32'h1);
      chk("lb_stall", 32'(stall_MEM), 32'h1);
      chk("lb_addr", mem_addr, 32'h100);
      chk("lb_we", 32'(mem_we), 32'h0);
      tick();
      chk("lb_bubble", 32'(regwrite_WB), 32'h0);
      chk("lb_rdhold", 32'(rd_WB), 32'd5);
      chk("lb_dhold", wb_data_WB, 32'h0000_1234);
      @(negedge clk);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h80FF_0000;
    #1 chk("lb_ackstall", 32'(stall_MEM), 32'h0);
    tick();
    chk("lb_data", wb_data_WB, 32'hFFFF_FF80);
    chk("lb_rw", 32'(regwrite_WB), 32'h1);
    chk("lb_rd", 32'(rd_WB), 32'd6);

    // LHU, zero-wait ack
    @(negedge clk);
    op(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 5'd7, 1'b1, 32'hBEEF_1234);
    #1;
    chk("lhu_req", 32'(mem_req), 32'h1);
    chk("lhu_stall", 32'(stall_MEM), 32'h0);
    tick();
    chk("lhu_data", wb_data_WB, 32'h0000_BEEF);
    @(negedge clk);
    idle_in();
    #1 chk("lhu_idle", 32'(mem_req), 32'h0);

    // LH signed, low half
    @(negedge clk);
    op(1'b1, 1'b0, 3'b001, 32'h200, 32'h0, 5'd8, 1'b1, 32'h1234_8001);
    tick();
    chk("lh_data", wb_data_WB, 32'hFFFF_8001);

    // SB
    @(negedge clk);
    op(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000_00AB, 5'd3, 1'b1, 32'h0);
    #1;
    chk("sb_we", 32'(mem_we), 32'h1);
    chk("sb_strb", 32'(mem_wstrb), 32'h2);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", mem_addr, 32'h300);
    tick();
    chk("sb_rw", 32'(regwrite_WB), 32'h0);

    // SH upper half
    @(negedge clk);
    op(1'b0, 1'b1, 3'b001, 32'h302, 32'h1234_CDEF, 5'd3, 1'b1, 32'h0);
    #1;
    chk("sh_strb", 32'(mem_wstrb), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hCDEF_CDEF);

    // memread and memwrite both set: a store
    @(negedge clk);
    op(1'b1, 1'b1, 3'b010, 32'h500, 32'hDEAD_BEEF, 5'd4, 1'b1, 32'h0);
    #1;
    chk("sw_we", 32'(mem_we), 32'h1);
    chk("sw_strb", 32'(mem_wstrb), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("sw_rw", 32'(regwrite_WB), 32'h0);

    // LW
    @(negedge clk);
    op(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 5'd9, 1'b1, 32'hCAFE_F00D);
    tick();
    chk("lw_data", wb_data_WB, 32'hCAFE_F00D);
    chk("lw_rd", 32'(rd_WB), 32'd9);

    // Stray ack with no access
    @(negedge clk);
    idle_in();
    mem_ack = 1'b1;
    #1;
    chk("stray_req", 32'(mem_req), 32'h0);
    chk("stray_stall", 32'(stall_MEM), 32'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1 chk("stray_idle", 32'(mem_req), 32'h0);

`ifdef MISALIGN_CHECK_EN
    @(negedge clk);
    op(1'b1, 1'b0, 3'b010, 32'h402, 32'h0, 5'd11, 1'b0, 32'h0);
    #1;
    chk("mis_req", 32'(mem_req), 32'h0);
    chk("mis_stall", 32'(stall_MEM), 32'h0);
    tick();
    chk("mis_flag", 32'(misalign_WB), 32'h1);
    chk("mis_addr", misalign_addr_WB, 32'h402);
    chk("mis_rw", 32'(regwrite_WB), 32'h0);
    @(negedge clk);
    idle_in();
    tick();
    chk("mis_clear", 32'(misalign_WB), 32'h0);
`else
    @(negedge clk);
    op(1'b1, 1'b0, 3'b010, 32'h402, 32'h0, 5'd11, 1'b1, 32'h1111_2222);
    #1;
    chk("w_req", 32'(mem_req), 32'h1);
    chk("w_addr", mem_addr, 32'h400);
    tick();
    chk("w_data", wb_data_WB, 32'h1111_2222);
    chk("w_mis", 32'(misalign_WB), 32'h0);
    @(negedge clk);
    op(1'b1, 1'b0, 3'b001, 32'h203, 32'h0, 5'd12, 1'b1, 32'h8000_1111);
    tick();
    chk("h_odd", wb_data_WB, 32'hFFFF_8000);
`endif

    // Reset while waiting on the bus
    @(negedge clk);
    op(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd10, 1'b0, 32'h0);
    tick();
    chk("wait_stall", 32'(stall_MEM), 32'h1);
    reset = 1'b1;
    #1;
    chk("ar_req", 32'(mem_req), 32'h0);
    chk("ar_stall", 32'(stall_MEM), 32'h0);
    chk("ar_rw", 32'(regwrite_WB), 32'h0);
    chk("ar_rd", 32'(rd_WB), 32'h0);
    chk("ar_data", wb_data_WB, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle_in();
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    #1;
    chk("late_req", 32'(mem_req), 32'h0);
    chk("late_stall", 32'(stall_MEM), 32'h0);
    tick();
    chk("late_rw", 32'(regwrite_WB), 32'h0);
    chk("late_data", wb_data_WB, 32'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1 chk("late_idle", 32'(mem_req), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
